// File: rtl/gx4000_pkg.sv
// Shared GX4000 subsystem types: ROM address width, grant owner encoding and
// the issue/wait access sequencer states.
// Used by the cartridge ROM arbiter and the ASIC register-bus arbiter.
package gx4000_pkg;

  localparam int GX_ROM_AW = 23;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LOAD = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_DMA  = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/gx4000_arb_pick.sv
// Purpose : fixed-priority winner select (load > urgent dma > cpu > dma).
// Latency : purely combinational, zero cycles.
// Backpressure: none; caller decides when the winner is sampled.
// Ports: load_req/cpu_req/dma_req request levels, dma_urgent starvation flag,
//        winner = selected owner (GNT_NONE when nothing is requested).
module gx4000_arb_pick
  import gx4000_pkg::*;
(
  input  logic   load_req,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   dma_urgent,
  output grant_t winner
);

  always_comb begin
    winner = GNT_NONE;
    if (load_req)
      winner = GNT_LOAD;
    else if (dma_req && dma_urgent)
      winner = GNT_DMA;
    else if (cpu_req)
      winner = GNT_CPU;
    else if (dma_req)
      winner = GNT_DMA;
  end

endmodule

// File: rtl/gx4000_cart_arbiter.sv
// Purpose : shares the cartridge ROM port between loader, CPU and sound DMA.
// Latency : req in IDLE at cycle 0 -> strobe cycle 1 -> ack cycle 3 at the earliest.
// Backpressure: requests held until ack; memory stalls via mem_ready, TIMEOUT aborts.
// Ports: load/cpu/dma request+address (+load data, cpu/dma q) with one-cycle
//        acks; mem_* single-access memory port; busy, grant and sticky timeout_err.
module gx4000_cart_arbiter
  import gx4000_pkg::*;
#(
  parameter int ADDR_W       = GX_ROM_AW,
  parameter int DMA_MAX_WAIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_q,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic [7:0]        dma_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int DW_W = $clog2(DMA_MAX_WAIT + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [DW_W-1:0] DMA_MAX_C = DW_W'(DMA_MAX_WAIT);
  localparam logic [WC_W-1:0] TIMEOUT_C = WC_W'(TIMEOUT);

  arb_state_t        state, state_next;
  grant_t            owner, pick;
  logic [DW_W-1:0]   dma_wait;
  logic [WC_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] pick_addr;

  // Requests only matter in IDLE; other states mask them so that a request
  // overlapping DONE is deferred to the next IDLE cycle.
  gx4000_arb_pick u_pick (
    .load_req   (load_req && state == IDLE),
    .cpu_req    (cpu_req  && state == IDLE),
    .dma_req    (dma_req  && state == IDLE),
    .dma_urgent (dma_wait >= DMA_MAX_C),
    .winner     (pick)
  );

  always_comb begin
    pick_addr = '0;
    case (pick)
      GNT_LOAD: pick_addr = load_addr;
      GNT_CPU:  pick_addr = cpu_addr;
      GNT_DMA:  pick_addr = dma_addr;
      default:  pick_addr = '0;
    endcase
  end

  assign busy  = (state != IDLE);
  assign grant = owner;

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    load_ack   = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    case (state)
      IDLE: if (pick != GNT_NONE) state_next = ISSUE;
      ISSUE: begin
        mem_wr     = (owner == GNT_LOAD);
        mem_rd     = (owner != GNT_LOAD);
        state_next = WAIT;
      end
      // A ready arriving on the timeout cycle still counts as a real completion.
      WAIT: if (mem_ready || wait_cnt == TIMEOUT_C) state_next = DONE;
      DONE: begin
        load_ack   = (owner == GNT_LOAD);
        cpu_ack    = (owner == GNT_CPU);
        dma_ack    = (owner == GNT_DMA);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner       <= GNT_NONE;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_q       <= '0;
      dma_q       <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      dma_wait    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            owner    <= pick;
            mem_addr <= pick_addr;
            if (pick == GNT_LOAD)
              mem_din <= load_data;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (mem_ready) begin
            if (owner == GNT_CPU) cpu_q <= mem_q;
            if (owner == GNT_DMA) dma_q <= mem_q;
          end else if (wait_cnt == TIMEOUT_C) begin
            if (owner == GNT_CPU) cpu_q <= 8'hFF;
            if (owner == GNT_DMA) dma_q <= 8'hFF;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: owner <= GNT_NONE;
        default: owner <= GNT_NONE;
      endcase

      // Starvation counter: runs while DMA is pending and not the owner.
      if (!dma_req || pick == GNT_DMA)
        dma_wait <= '0;
      else if (owner != GNT_DMA && dma_wait < DMA_MAX_C)
        dma_wait <= dma_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_gx4000_cart_arbiter.sv
// Directed bench for the cartridge ROM arbiter with a latency-programmable memory model.
module tb_gx4000_cart_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
  logic [22:0] load_addr = '0, cpu_addr = '0, dma_addr = '0;
  logic [7:0]  load_data = '0;
  logic        load_ack, cpu_ack, dma_ack;
  logic [7:0]  cpu_q, dma_q, mem_din;
  logic [22:0] mem_addr;
  logic        mem_wr, mem_rd, busy, timeout_err;
  logic [1:0]  grant;
  logic [7:0]  mem_q = 8'h00;
  logic        mem_ready;
  logic        resp_ready = 1'b0;
  logic        stray_ready = 1'b0;

  int mem_lat = 0;           // 0: memory never answers
  logic [7:0] mem_data = 8'h00;
  int rcnt = 0;

  int n_checks = 0;
  int n_err = 0;

  assign mem_ready = resp_ready | stray_ready;

  gx4000_cart_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_q(dma_q),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_q(mem_q), .mem_ready(mem_ready),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory model: mem_ready pulses mem_lat cycles after the strobe cycle.
  always @(negedge clk_sys) begin
    resp_ready <= 1'b0;
    if ((mem_rd || mem_wr) && mem_lat > 0) begin
      rcnt <= mem_lat;
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) begin
        resp_ready <= 1'b1;
        mem_q      <= mem_data;
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      1: return load_ack;
      2: return cpu_ack;
      default: return dma_ack;
    endcase
  endfunction

  // Ticks until the selected ack is seen or max cycles pass; cyc = ticks taken.
  task automatic wait_ack(input int which, input int max, output int cyc);
    cyc = 0;
    while (ack_of(which) !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  int acks;
  int ns;
  int s_cyc[8];
  int s_gnt[8];

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_strobes", {mem_wr, mem_rd}, 0);
    chk("rst_acks", {load_ack, cpu_ack, dma_ack}, 0);
    chk("rst_q", {cpu_q, dma_q}, 0);
    chk("rst_mem", {mem_addr, mem_din}, 0);
    chk("rst_terr", timeout_err, 0);

    // 1: single CPU read, ready 2 cycles after strobe -> ack at cycle 4
    mem_lat = 2; mem_data = 8'hA5;
    cpu_addr = 23'h001234; cpu_req = 1'b1;
    tick();
    chk("t1_grant_issue", grant, 2);
    chk("t1_rd", mem_rd, 1);
    chk("t1_wr", mem_wr, 0);
    chk("t1_addr", mem_addr, 32'h1234);
    cpu_addr = 23'h7FFFFF;  // must be ignored after grant
    wait_ack(2, 20, cyc);
    chk("t1_ack_cycle", cyc, 3);
    chk("t1_cpu_q", cpu_q, 8'hA5);
    chk("t1_addr_held", mem_addr, 32'h1234);
    chk("t1_grant_done", grant, 2);
    cpu_req = 1'b0;
    tick();
    chk("t1_grant_idle", grant, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_ack_once", cpu_ack, 0);

    // 2: load and cpu simultaneous -> load first, then cpu after an IDLE
    mem_lat = 1; mem_data = 8'h77;
    load_addr = 23'h000ABC; load_data = 8'h5A; load_req = 1'b1;
    cpu_addr = 23'h000100; cpu_req = 1'b1;
    tick();
    chk("t2_grant_load", grant, 1);
    chk("t2_wr", mem_wr, 1);
    chk("t2_rd", mem_rd, 0);
    chk("t2_din", mem_din, 8'h5A);
    chk("t2_addr", mem_addr, 32'hABC);
    tick(); tick();
    chk("t2_load_ack", load_ack, 1);
    chk("t2_cpu_ack_early", cpu_ack, 0);
    load_req = 1'b0;
    tick();
    chk("t2_idle_gap", {busy, grant}, 0);
    chk("t2_load_ack_once", load_ack, 0);
    tick();
    chk("t2_grant_cpu", grant, 2);
    chk("t2_rd_cpu", mem_rd, 1);
    chk("t2_addr_cpu", mem_addr, 32'h100);
    wait_ack(2, 20, cyc);
    chk("t2_cpu_ack_cycle", cyc, 2);
    chk("t2_cpu_q", cpu_q, 8'h77);
    cpu_req = 1'b0;
    tick();

    // 3: cpu and dma both held, latency 1 -> dma wins after 8 pending cycles
    mem_lat = 1; mem_data = 8'h3C;
    cpu_addr = 23'h000200; dma_addr = 23'h000300;
    cpu_req = 1'b1; dma_req = 1'b1;
    ns = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if ((mem_rd || mem_wr) && ns < 8) begin
        s_cyc[ns] = c;
        s_gnt[ns] = int'(grant);
        ns++;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    chk("t3_n_strobes", ns, 4);
    chk("t3_s0", {s_cyc[0][15:0], s_gnt[0][15:0]}, {16'd1, 16'd2});
    chk("t3_s1", {s_cyc[1][15:0], s_gnt[1][15:0]}, {16'd5, 16'd2});
    chk("t3_s2_dma", {s_cyc[2][15:0], s_gnt[2][15:0]}, {16'd9, 16'd3});
    chk("t3_s3_cleared", {s_cyc[3][15:0], s_gnt[3][15:0]}, {16'd13, 16'd2});
    chk("t3_dma_q", dma_q, 8'h3C);
    tick();
    chk("t3_idle", busy, 0);

    // 4: timeout -> ack 257 cycles after strobe, q=FF, sticky error
    mem_lat = 0;
    cpu_addr = 23'h000400; cpu_req = 1'b1;
    tick();
    chk("t4_rd", mem_rd, 1);
    wait_ack(2, 300, cyc);
    chk("t4_ack_cycle", cyc, 257);
    chk("t4_cpu_q", cpu_q, 8'hFF);
    chk("t4_terr", timeout_err, 1);
    cpu_req = 1'b0;
    tick();
    stray_ready = 1'b1;
    tick();
    stray_ready = 1'b0;
    chk("t4_stray_busy", busy, 0);
    chk("t4_stray_grant", grant, 0);
    chk("t4_stray_acks", {load_ack, cpu_ack, dma_ack}, 0);
    tick();
    chk("t4_sticky", timeout_err, 1);
    chk("t4_q_kept", cpu_q, 8'hFF);

    // 5: reset during WAIT, then memory answers -> no ack, all outputs cleared
    mem_lat = 4; mem_data = 8'h99;
    cpu_addr = 23'h000500; cpu_req = 1'b1;
    tick(); tick(); tick();
    chk("t5_in_wait", {busy, grant}, {1'b1, 2'd2});
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (load_ack || cpu_ack || dma_ack || busy) acks++;
      tick();
    end
    chk("t5_no_ack", acks, 0);
    chk("t5_terr_clr", timeout_err, 0);
    chk("t5_q_clr", {cpu_q, dma_q}, 0);
    chk("t5_mem_clr", {mem_addr, mem_din, mem_wr, mem_rd}, 0);
    chk("t5_grant", grant, 0);

    // 6: dma holds req one cycle past ack -> second access and ack
    mem_lat = 1; mem_data = 8'hC3;
    dma_addr = 23'h000600; dma_req = 1'b1;
    tick();
    chk("t6_grant", grant, 3);
    wait_ack(3, 20, cyc);
    chk("t6_ack1_cycle", cyc, 2);
    chk("t6_dma_q1", dma_q, 8'hC3);
    mem_data = 8'h42;
    tick();
    chk("t6_idle", {busy, grant}, 0);
    tick();
    dma_req = 1'b0;
    chk("t6_reissue", {mem_rd, grant}, {1'b1, 2'd3});
    wait_ack(3, 20, cyc);
    chk("t6_ack2_cycle", cyc, 2);
    chk("t6_dma_q2", dma_q, 8'h42);
    tick(); tick();
    chk("t6_quiet", {busy, dma_ack}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
